// File: rtl/song_recorder.sv
// Note recorder/player: captures {note, duration-in-ticks} runs from a keypad
// into a small register array and replays them with the original timing.
module song_recorder #(
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_record,
  input  logic                   start,
  input  logic                   stop,
  input  logic [3:0]             pressed_key,
  input  logic                   key_pressed,
  output logic [3:0]             note_to_play,
  output logic                   play_note,
  output logic                   note_buzzed,
  output logic [$clog2(DEPTH):0] rec_count,
  output logic                   full,
  output logic [1:0]             state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REC  = 2'b01,
    PLAY = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [PRE_W-1:0]   presc_q;
  logic               tick;
  logic [3:0]         run_note_q;
  logic [DUR_W-1:0]   run_dur_q;
  logic [CNT_W-1:0]   rec_count_q;
  logic [CNT_W-1:0]   idx_q;
  logic [DUR_W-1:0]   rem_q;
  logic [3:0]         note_q;
  logic               play_q;
  logic               buzz_q;
  logic [DUR_W+3:0]   mem [DEPTH];

  logic [3:0]         sampled;
  logic               note_change;
  logic               wr_en;
  logic               rec_enter;
  logic               play_enter;
  logic               play_next;
  logic [IDX_W-1:0]   fetch_addr;
  logic [DUR_W+3:0]   rd_word;
  logic [3:0]         rd_note;
  logic [DUR_W-1:0]   rd_dur;

  assign tick        = (state_q != IDLE) && (presc_q == PRE_LAST);
  assign sampled     = key_pressed ? pressed_key : 4'd0;
  assign note_change = (sampled != run_note_q);
  assign fetch_addr  = play_enter ? '0 : IDX_W'(idx_q + CNT_W'(1));
  assign rd_word     = mem[fetch_addr];
  assign rd_note     = rd_word[DUR_W+3:DUR_W];
  assign rd_dur      = rd_word[DUR_W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d    = state_q;
    wr_en      = 1'b0;
    rec_enter  = 1'b0;
    play_enter = 1'b0;
    play_next  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (mode_record) begin
            state_d   = REC;
            rec_enter = 1'b1;
          end else if (rec_count_q != '0) begin
            state_d    = PLAY;
            play_enter = 1'b1;
          end
        end
      end
      REC: begin
        if (stop) begin
          state_d = IDLE;
          wr_en   = (run_dur_q != '0) && (rec_count_q < DEPTH_C);
        end else if (note_change && (run_dur_q != '0)) begin
          wr_en = 1'b1;
          if (rec_count_q == DEPTH_C - CNT_W'(1)) state_d = IDLE;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick && (rem_q <= DUR_W'(1))) begin
          if (idx_q + CNT_W'(1) == rec_count_q) state_d = IDLE;
          else                                  play_next = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state is always assigned non-blocking.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Prescaler restarts on each REC/PLAY entry so ticks align with the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         presc_q <= '0;
    else if (rec_enter || play_enter || state_q == IDLE) presc_q <= '0;
    else if (tick)                                   presc_q <= '0;
    else                                             presc_q <= presc_q + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_count_q <= '0;
      run_note_q  <= '0;
      run_dur_q   <= '0;
    end else if (rec_enter) begin
      rec_count_q <= '0;
      run_note_q  <= '0;
      run_dur_q   <= '0;
    end else begin
      if (wr_en) rec_count_q <= rec_count_q + CNT_W'(1);
      if (state_q == REC) begin
        if (note_change) begin
          run_note_q <= sampled;
          run_dur_q  <= '0;
        end else if (tick && (run_dur_q != '1)) begin
          run_dur_q <= run_dur_q + DUR_W'(1);
        end
      end
    end
  end

  // NOTE: the note store is deliberately not reset; rec_count alone marks valid entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[rec_count_q[IDX_W-1:0]] <= {run_note_q, run_dur_q};
  end

  // Each entry is fetched straight into the output registers, so it sounds for exactly
  // its duration and the next entry takes over on the expiring tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      rem_q  <= '0;
      note_q <= '0;
      play_q <= 1'b0;
      buzz_q <= 1'b0;
    end else if (play_enter || play_next) begin
      idx_q  <= play_enter ? '0 : idx_q + CNT_W'(1);
      rem_q  <= rd_dur;
      note_q <= rd_note;
      play_q <= (rd_note != 4'd0);
      buzz_q <= (rd_note != 4'd0);
    end else begin
      buzz_q <= 1'b0;
      if (state_d != PLAY) begin
        note_q <= '0;
        play_q <= 1'b0;
      end else if (tick) begin
        rem_q <= rem_q - DUR_W'(1);
      end
    end
  end

  assign note_to_play = note_q;
  assign play_note    = play_q;
  assign note_buzzed  = buzz_q;
  assign rec_count    = rec_count_q;
  assign full         = (rec_count_q == DEPTH_C);
  assign state        = state_q;

endmodule
